// File: rtl/delimiter_detect_pkg.sv
// Shared MVB receive constants and types: delimiters, end marker, frame limits,
// pair classes and receiver states.
package delimiter_detect_pkg;

   localparam int unsigned DELIM_W  = 18;
   localparam int unsigned MAX_BITS = 320;
   localparam int unsigned CNT_W    = 10;

   localparam logic [DELIM_W-1:0] M_DELIM   = 18'b11_10_01_00_10_01_00_00_00;
   localparam logic [DELIM_W-1:0] S_DELIM   = 18'b11_11_11_11_01_10_11_01_10;
   localparam logic [3:0]         END_DELIM = 4'b0110;

   // Decoded data bits of the end delimiter (first half-bit of each pair)
   localparam logic [1:0] END_BITS = {END_DELIM[3], END_DELIM[1]};

   typedef enum logic [1:0] {
      FMT_MASTER = 2'b01,
      FMT_SLAVE  = 2'b10,
      FMT_END    = 2'b11
   } fmt_e;

   typedef enum logic [1:0] {
      PAIR_VALID0 = 2'b00,
      PAIR_VALID1 = 2'b01,
      PAIR_IDLE00 = 2'b10,
      PAIR_VIOL11 = 2'b11
   } pair_e;

   typedef enum logic {
      HUNT = 1'b0,
      DATA = 1'b1
   } state_e;

endpackage

// File: rtl/mvb_pair_decode.sv
// Half-bit pair tracker: toggles the pair phase and classifies each completed
// Manchester pair.
module mvb_pair_decode
   import delimiter_detect_pkg::*;
(
   input  logic       clk_3M,
   input  logic       reset,
   input  logic       clear,
   input  logic       step,
   input  logic       rx_in,
   output logic       pair_rdy_c,
   output logic [1:0] pair_c
);

   logic phase;
   logic first_half;

   always_ff @(posedge clk_3M) begin
      if (reset || clear) begin
         phase      <= 1'b0;
         first_half <= 1'b0;
      end else if (step) begin
         phase <= ~phase;
         if (!phase) first_half <= rx_in;
      end
   end

   assign pair_rdy_c = step & phase;

   always_comb begin
      case ({first_half, rx_in})
         2'b10:   pair_c = PAIR_VALID1;
         2'b01:   pair_c = PAIR_VALID0;
         2'b00:   pair_c = PAIR_IDLE00;
         default: pair_c = PAIR_VIOL11;
      endcase
   end

endmodule

// File: rtl/delimiter_detect.sv
// MVB receive front end: hunts for master/slave start delimiters, decodes data
// pairs through a 2-deep hold so end-delimiter bits are never emitted.
module delimiter_detect
   import delimiter_detect_pkg::*;
(
   input  logic             clk_3M,
   input  logic             reset,
   input  logic             rx_in,
   input  logic             rx_en,
   output logic             m_start,
   output logic             s_start,
   output logic             frame_act,
   output logic             data_valid,
   output logic             data_bit,
   output logic             frame_end,
   output logic             code_err,
   output logic [CNT_W-1:0] bit_count
);

   state_e             state, state_d;
   logic [DELIM_W-2:0] sr, sr_d;
   logic [DELIM_W-1:0] window;
   logic               h_old, h_old_d, h_new, h_new_d;
   logic [1:0]         h_cnt, h_cnt_d;
   logic [CNT_W-1:0]   bit_count_d;
   logic               m_start_d, s_start_d, frame_act_d, data_valid_d;
   logic               data_bit_d, frame_end_d, code_err_d;
   logic               pair_rdy;
   logic [1:0]         pair_raw;
   pair_e              pair;
   logic               pair_bit;

   mvb_pair_decode u_pair (
      .clk_3M     (clk_3M),
      .reset      (reset),
      .clear      ((state == HUNT) | ~rx_en),
      .step       ((state == DATA) & rx_en),
      .rx_in      (rx_in),
      .pair_rdy_c (pair_rdy),
      .pair_c     (pair_raw)
   );

   assign pair     = pair_e'(pair_raw);
   assign pair_bit = (pair == PAIR_VALID1);
   assign window   = {sr, rx_in};

   always_ff @(posedge clk_3M) begin
      if (reset) begin
         state      <= HUNT;
         sr         <= '0;
         h_old      <= 1'b0;
         h_new      <= 1'b0;
         h_cnt      <= 2'd0;
         bit_count  <= '0;
         m_start    <= 1'b0;
         s_start    <= 1'b0;
         frame_act  <= 1'b0;
         data_valid <= 1'b0;
         data_bit   <= 1'b0;
         frame_end  <= 1'b0;
         code_err   <= 1'b0;
      end else begin
         state      <= state_d;
         sr         <= sr_d;
         h_old      <= h_old_d;
         h_new      <= h_new_d;
         h_cnt      <= h_cnt_d;
         bit_count  <= bit_count_d;
         m_start    <= m_start_d;
         s_start    <= s_start_d;
         frame_act  <= frame_act_d;
         data_valid <= data_valid_d;
         data_bit   <= data_bit_d;
         frame_end  <= frame_end_d;
         code_err   <= code_err_d;
      end
   end

   always_comb begin
      state_d      = state;
      sr_d         = sr;
      h_old_d      = h_old;
      h_new_d      = h_new;
      h_cnt_d      = h_cnt;
      bit_count_d  = bit_count;
      m_start_d    = 1'b0;
      s_start_d    = 1'b0;
      frame_act_d  = frame_act;
      data_valid_d = 1'b0;
      data_bit_d   = data_bit;
      frame_end_d  = 1'b0;
      code_err_d   = 1'b0;

      if (!rx_en) begin
         state_d     = HUNT;
         sr_d        = '0;
         h_cnt_d     = 2'd0;
         frame_act_d = 1'b0;
      end else begin
         sr_d = window[DELIM_W-2:0];
         case (state)
            HUNT: begin
               if (window == M_DELIM || window == S_DELIM) begin
                  m_start_d   = (window == M_DELIM);
                  s_start_d   = (window == S_DELIM);
                  state_d     = DATA;
                  bit_count_d = '0;
                  frame_act_d = 1'b1;
                  h_cnt_d     = 2'd0;
               end
            end
            DATA: begin
               if (pair_rdy) begin
                  case (pair)
                     PAIR_VALID0, PAIR_VALID1: begin
                        if (h_cnt == 2'd2 && bit_count == CNT_W'(MAX_BITS)) begin
                           code_err_d = 1'b1;
                        end else begin
                           if (h_cnt == 2'd2) begin
                              data_valid_d = 1'b1;
                              data_bit_d   = h_old;
                              bit_count_d  = bit_count + CNT_W'(1);
                           end else begin
                              h_cnt_d = h_cnt + 2'd1;
                           end
                           h_old_d = h_new;
                           h_new_d = pair_bit;
                        end
                     end
                     PAIR_IDLE00: begin
                        if (h_cnt == 2'd2 && {h_old, h_new} == END_BITS)
                           frame_end_d = 1'b1;
                        else
                           code_err_d = 1'b1;
                     end
                     default: code_err_d = 1'b1;
                  endcase
                  // Any terminating event returns to a cleared hunt window
                  if (frame_end_d || code_err_d) begin
                     state_d     = HUNT;
                     sr_d        = '0;
                     h_cnt_d     = 2'd0;
                     frame_act_d = 1'b0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

endmodule
